// File: rtl/yarp_decode_stage.sv
// yarp_decode_stage
//   Registered, handshaked RV32I instruction-decode stage for the yarp core.
//   A raw instruction and its PC are decoded into the core control bundle.
//   The bundle is held in an output register behind a valid/ready pair, so
//   fetch and execute can stall independently.
//
// Build option:
//   YARP_RV32M_EN - when defined, OP with funct7=0000001 decodes as an M-op.
//                   It is held for MDU_LAT cycles before its bundle is valid.
//                   When undefined, that encoding is illegal, and no counter
//                   or BUSY state exists.
//
// Parameters:
//   PC_W    - width of the PC sideband
//   MDU_LAT - cycles from acceptance of an M-op to ctrl_valid_o (>= 1)
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   instr_valid_i/instr_ready_o - fetch-side handshake
//   instr_i, pc_i               - instruction word and its PC
//   flush_i                     - kill held / in-flight instruction
//   ctrl_valid_o/ctrl_ready_i   - execute-side handshake
//   pc_o, rd_o, rs1_o, rs2_o    - registered sideband fields
//   pc_sel_o .. rf_wr_en_o      - single-bit control bundle
//   alu_func_o                  - [4]=M-op; [3:0] ALU op or {0,funct3}
//   rf_wr_data_o                - write-back select (ALU/MEM/IMM/PC)
//   data_byte_o                 - memory access size (BYTE/HALF/WORD)
//   illegal_o                   - unrecognised opcode/funct combination
module yarp_decode_stage #(
    parameter int PC_W    = 32,
    parameter int MDU_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            instr_ready_o,
    input  logic            flush_i,
    output logic            ctrl_valid_o,
    input  logic            ctrl_ready_i,
    output logic [PC_W-1:0] pc_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            pc_sel_o,
    output logic            op1sel_o,
    output logic            op2sel_o,
    output logic            data_req_o,
    output logic            data_wr_o,
    output logic            zero_extnd_o,
    output logic            rf_wr_en_o,
    output logic [4:0]      alu_func_o,
    output logic [1:0]      rf_wr_data_o,
    output logic [1:0]      data_byte_o,
    output logic            illegal_o
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLT  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2,
        WB_PC  = 2'd3
    } wb_sel_e;

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // ---------------- combinational decode ----------------
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_pc_sel, w_op1sel, w_op2sel, w_data_req, w_data_wr;
    logic       w_zero_extnd, w_rf_wr_en, w_illegal, w_is_mop;
    alu_op_e    w_alu;
    wb_sel_e    w_wb_sel;
    logic [1:0] w_data_byte;
    logic [4:0] w_alu_func;

    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    always_comb begin
        w_pc_sel     = 1'b0;
        w_op1sel     = 1'b0;
        w_op2sel     = 1'b0;
        w_data_req   = 1'b0;
        w_data_wr    = 1'b0;
        w_zero_extnd = 1'b0;
        w_rf_wr_en   = 1'b0;
        w_illegal    = 1'b0;
        w_is_mop     = 1'b0;
        w_alu        = ALU_ADD;
        w_wb_sel     = WB_ALU;
        w_data_byte  = 2'b00;
        case (instr_i[6:0])
            OPC_OP: begin
                if (w_funct7 == 7'b0000001) begin
`ifdef YARP_RV32M_EN
                    w_is_mop   = 1'b1;
                    w_rf_wr_en = 1'b1;
`else
                    w_illegal  = 1'b1;
`endif
                end else begin
                    w_rf_wr_en = 1'b1;
                    w_alu      = alu_from_funct(w_funct3, w_funct7[5]);
                end
            end
            OPC_OPIMM: begin
                w_rf_wr_en = 1'b1;
                w_op2sel   = 1'b1;
                // For ADDI the upper bits are immediate, so only shifts look at funct7
                w_alu      = alu_from_funct(w_funct3, (w_funct3 == 3'd5) && w_funct7[5]);
            end
            OPC_LOAD: begin
                if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7) begin
                    w_illegal = 1'b1;
                end else begin
                    w_rf_wr_en   = 1'b1;
                    w_op2sel     = 1'b1;
                    w_data_req   = 1'b1;
                    w_wb_sel     = WB_MEM;
                    w_data_byte  = w_funct3[1:0];
                    w_zero_extnd = w_funct3[2];
                end
            end
            OPC_STORE: begin
                if (w_funct3 >= 3'd3) begin
                    w_illegal = 1'b1;
                end else begin
                    w_data_req  = 1'b1;
                    w_data_wr   = 1'b1;
                    w_op2sel    = 1'b1;
                    w_data_byte = w_funct3[1:0];
                end
            end
            OPC_BRANCH: begin
                w_op1sel = 1'b1;
                w_op2sel = 1'b1;
            end
            OPC_JAL: begin
                w_rf_wr_en = 1'b1;
                w_op1sel   = 1'b1;
                w_op2sel   = 1'b1;
                w_pc_sel   = 1'b1;
                w_wb_sel   = WB_PC;
            end
            OPC_JALR: begin
                w_rf_wr_en = 1'b1;
                w_op2sel   = 1'b1;
                w_pc_sel   = 1'b1;
                w_wb_sel   = WB_PC;
            end
            OPC_LUI: begin
                w_rf_wr_en = 1'b1;
                w_wb_sel   = WB_IMM;
            end
            OPC_AUIPC: begin
                w_rf_wr_en = 1'b1;
                w_op1sel   = 1'b1;
                w_op2sel   = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_alu_func = w_is_mop ? {2'b10, w_funct3} : {1'b0, w_alu};

    // ---------------- handshake / state ----------------
    logic w_busy;
    logic w_accept;

`ifdef YARP_RV32M_EN
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    assign w_busy = (r_state == ST_BUSY);
`else
    logic w_unused_lat;
    assign w_unused_lat = (MDU_LAT != 0);
    assign w_busy = 1'b0;
`endif

    assign instr_ready_o = !reset && !flush_i && !w_busy && (!ctrl_valid_o || ctrl_ready_i);
    assign w_accept      = instr_valid_i && instr_ready_o;

    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_rd, r_rs1, r_rs2, r_alu_func;
    logic            r_valid, r_pc_sel, r_op1sel, r_op2sel, r_data_req, r_data_wr;
    logic            r_zero_extnd, r_rf_wr_en, r_illegal;
    logic [1:0]      r_wb_sel, r_data_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_pc_sel     <= 1'b0;
            r_op1sel     <= 1'b0;
            r_op2sel     <= 1'b0;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_zero_extnd <= 1'b0;
            r_rf_wr_en   <= 1'b0;
            r_alu_func   <= '0;
            r_wb_sel     <= '0;
            r_data_byte  <= '0;
            r_illegal    <= 1'b0;
`ifdef YARP_RV32M_EN
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
`endif
        end else if (flush_i) begin
            r_valid <= 1'b0;
`ifdef YARP_RV32M_EN
            r_state <= ST_IDLE;
            r_cnt   <= '0;
`endif
        end else if (w_accept) begin
            r_pc         <= pc_i;
            r_rd         <= instr_i[11:7];
            r_rs1        <= instr_i[19:15];
            r_rs2        <= instr_i[24:20];
            r_pc_sel     <= w_pc_sel;
            r_op1sel     <= w_op1sel;
            r_op2sel     <= w_op2sel;
            r_data_req   <= w_data_req;
            r_data_wr    <= w_data_wr;
            r_zero_extnd <= w_zero_extnd;
            r_rf_wr_en   <= w_rf_wr_en;
            r_alu_func   <= w_alu_func;
            r_wb_sel     <= w_wb_sel;
            r_data_byte  <= w_data_byte;
            r_illegal    <= w_illegal;
`ifdef YARP_RV32M_EN
            if (w_is_mop && (MDU_LAT > 1)) begin
                r_valid <= 1'b0;
                r_state <= ST_BUSY;
                r_cnt   <= CNT_W'(MDU_LAT - 1);
            end else begin
                r_valid <= 1'b1;
            end
`else
            r_valid <= 1'b1;
`endif
        end
`ifdef YARP_RV32M_EN
        // Output appears on the edge after the counter has already hit zero,
        // giving exactly MDU_LAT edges from acceptance
        else if (r_state == ST_BUSY) begin
            if (r_cnt == '0) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
`endif
        else if (ctrl_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ctrl_valid_o = r_valid;
    assign pc_o         = r_pc;
    assign rd_o         = r_rd;
    assign rs1_o        = r_rs1;
    assign rs2_o        = r_rs2;
    assign pc_sel_o     = r_pc_sel;
    assign op1sel_o     = r_op1sel;
    assign op2sel_o     = r_op2sel;
    assign data_req_o   = r_data_req;
    assign data_wr_o    = r_data_wr;
    assign zero_extnd_o = r_zero_extnd;
    assign rf_wr_en_o   = r_rf_wr_en;
    assign alu_func_o   = r_alu_func;
    assign rf_wr_data_o = r_wb_sel;
    assign data_byte_o  = r_data_byte;
    assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_yarp_decode_stage.sv
// Directed testbench for yarp_decode_stage. M-extension checks compile only
// when YARP_RV32M_EN is defined; otherwise the M encoding is checked as illegal.
module tb_yarp_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        instr_ready_o;
    logic        flush_i;
    logic        ctrl_valid_o;
    logic        ctrl_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic        pc_sel_o, op1sel_o, op2sel_o, data_req_o, data_wr_o;
    logic        zero_extnd_o, rf_wr_en_o, illegal_o;
    logic [4:0]  alu_func_o;
    logic [1:0]  rf_wr_data_o, data_byte_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    yarp_decode_stage #(.PC_W(32), .MDU_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .instr_ready_o(instr_ready_o), .flush_i(flush_i),
        .ctrl_valid_o(ctrl_valid_o), .ctrl_ready_i(ctrl_ready_i),
        .pc_o(pc_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .pc_sel_o(pc_sel_o), .op1sel_o(op1sel_o), .op2sel_o(op2sel_o),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o),
        .zero_extnd_o(zero_extnd_o), .rf_wr_en_o(rf_wr_en_o),
        .alu_func_o(alu_func_o), .rf_wr_data_o(rf_wr_data_o),
        .data_byte_o(data_byte_o), .illegal_o(illegal_o)
    );

    // {pc_sel, op1sel, op2sel, data_req, data_wr, zero_extnd, rf_wr_en, alu[4:0], wb[1:0], byte[1:0], illegal}
    logic [16:0] ctrl_pack;
    assign ctrl_pack = {pc_sel_o, op1sel_o, op2sel_o, data_req_o, data_wr_o,
                        zero_extnd_o, rf_wr_en_o, alu_func_o, rf_wr_data_o,
                        data_byte_o, illegal_o};

    function automatic logic [16:0] ctl(input logic pcs, input logic o1, input logic o2,
                                        input logic dreq, input logic dwr, input logic zx,
                                        input logic we, input logic [4:0] alu,
                                        input logic [1:0] wb, input logic [1:0] by,
                                        input logic ill);
        return {pcs, o1, o2, dreq, dwr, zx, we, alu, wb, by, ill};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_i = v;
        instr_i       = ins;
        pc_i          = pc;
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LBU  = 32'h0000C103;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    logic [31:0] tab_instr [14];
    logic [16:0] tab_exp   [14];
    int          vcount;

    initial begin
        tab_instr[0]  = 32'h40208133; tab_exp[0]  = ctl(0,0,0,0,0,0,1,5'd1,2'd0,2'd0,0); // sub
        tab_instr[1]  = 32'h4030D093; tab_exp[1]  = ctl(0,0,1,0,0,0,1,5'd4,2'd0,2'd0,0); // srai
        tab_instr[2]  = 32'h0020A223; tab_exp[2]  = ctl(0,0,1,1,1,0,0,5'd0,2'd0,2'd2,0); // sw
        tab_instr[3]  = 32'h000000EF; tab_exp[3]  = ctl(1,1,1,0,0,0,1,5'd0,2'd3,2'd0,0); // jal
        tab_instr[4]  = 32'h00008067; tab_exp[4]  = ctl(1,0,1,0,0,0,1,5'd0,2'd3,2'd0,0); // jalr
        tab_instr[5]  = 32'h123452B7; tab_exp[5]  = ctl(0,0,0,0,0,0,1,5'd0,2'd2,2'd0,0); // lui
        tab_instr[6]  = 32'h00000097; tab_exp[6]  = ctl(0,1,1,0,0,0,1,5'd0,2'd0,2'd0,0); // auipc
        tab_instr[7]  = 32'h00208063; tab_exp[7]  = ctl(0,1,1,0,0,0,0,5'd0,2'd0,2'd0,0); // beq
        tab_instr[8]  = 32'h0000007F; tab_exp[8]  = ctl(0,0,0,0,0,0,0,5'd0,2'd0,2'd0,1); // bad opcode
        tab_instr[9]  = 32'h00003023; tab_exp[9]  = ctl(0,0,0,0,0,0,0,5'd0,2'd0,2'd0,1); // store f3=3
        tab_instr[10] = 32'h00003003; tab_exp[10] = ctl(0,0,0,0,0,0,0,5'd0,2'd0,2'd0,1); // load f3=3
        tab_instr[11] = 32'h00109183; tab_exp[11] = ctl(0,0,1,1,0,0,1,5'd0,2'd1,2'd1,0); // lh
        tab_instr[12] = 32'h003130B3; tab_exp[12] = ctl(0,0,0,0,0,0,1,5'd8,2'd0,2'd0,0); // sltu
        tab_instr[13] = 32'hC0000093; tab_exp[13] = ctl(0,0,1,0,0,0,1,5'd0,2'd0,2'd0,0); // addi -1024

        reset        = 1'b1;
        flush_i      = 1'b0;
        ctrl_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        check("reset_valid", ctrl_valid_o, 0);
        check("reset_ctrl", ctrl_pack, 0);
        check("reset_side", {pc_o, rd_o, rs1_o, rs2_o}, 0);
        check("reset_ready", instr_ready_o, 0);

        // single ADDI
        reset        = 1'b0;
        ctrl_ready_i = 1'b1;
        drive(1'b1, I_ADDI, 32'h100);
        #1;
        check("addi_ready", instr_ready_o, 1);
        step();
        check("addi_valid", ctrl_valid_o, 1);
        check("addi_ctrl", ctrl_pack, ctl(0,0,1,0,0,0,1,5'd0,2'd0,2'd0,0));
        check("addi_rd", rd_o, 1);
        check("addi_pc", pc_o, 32'h100);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("addi_drop", ctrl_valid_o, 0);

        // LBU held under backpressure, then second instruction on consume
        ctrl_ready_i = 1'b0;
        drive(1'b1, I_LBU, 32'h200);
        step();
        check("lbu_valid", ctrl_valid_o, 1);
        check("lbu_ctrl", ctrl_pack, ctl(0,0,1,1,0,1,1,5'd0,2'd1,2'd0,0));
        check("lbu_rd_rs1", {rd_o, rs1_o}, {5'd2, 5'd1});
        drive(1'b1, I_ADD, 32'h204);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("lbu_hold_ready", instr_ready_o, 0);
            check("lbu_hold_ctrl", {ctrl_valid_o, ctrl_pack, pc_o},
                  {1'b1, ctl(0,0,1,1,0,1,1,5'd0,2'd1,2'd0,0), 32'h200});
            step();
        end
        ctrl_ready_i = 1'b1;
        #1;
        check("consume_ready", instr_ready_o, 1);
        step();
        check("second_valid", ctrl_valid_o, 1);
        check("second_ctrl", ctrl_pack, ctl(0,0,0,0,0,0,1,5'd0,2'd0,2'd0,0));
        check("second_side", {pc_o, rd_o}, {32'h204, 5'd3});
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("second_drop", ctrl_valid_o, 0);

        // decode table, back-to-back
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, tab_instr[i], 32'h300 + 32'(4 * i));
            step();
            check($sformatf("tab%0d_valid", i), ctrl_valid_o, 1);
            check($sformatf("tab%0d_ctrl", i), ctrl_pack, tab_exp[i]);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("tab_drop", ctrl_valid_o, 0);

`ifdef YARP_RV32M_EN
        // MUL with MDU_LAT=4
        drive(1'b1, I_MUL, 32'h500);
        #1;
        check("mul_ready", instr_ready_o, 1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("mul_c%0d_valid", k), ctrl_valid_o, 0);
            check($sformatf("mul_c%0d_ready", k), instr_ready_o, 0);
            step();
        end
        check("mul_c4_valid", ctrl_valid_o, 0);
        step();
        check("mul_out_valid", ctrl_valid_o, 1);
        check("mul_ctrl", ctrl_pack, ctl(0,0,0,0,0,0,1,5'b10000,2'd0,2'd0,0));
        check("mul_side", {pc_o, rd_o}, {32'h500, 5'd3});
        step();
        check("mul_drop", ctrl_valid_o, 0);

        // flush during BUSY with a coincident valid instruction
        drive(1'b1, I_MUL, 32'h600);
        step();
        drive(1'b1, I_ADDI, 32'h640);
        flush_i = 1'b1;
        #1;
        check("flush_busy_ready", instr_ready_o, 0);
        step();
        check("flush_busy_valid", ctrl_valid_o, 0);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check("flush_busy_idle", instr_ready_o, 1);
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ctrl_valid_o) vcount++;
        end
        check("flush_busy_nostale", vcount, 0);
        check("flush_busy_pc", pc_o, 32'h600);

        // reset mid-BUSY
        drive(1'b1, I_MUL, 32'h700);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ctrl_valid_o) vcount++;
        end
        check("rst_busy_nooutput", vcount, 0);
        check("rst_busy_side", {pc_o, rd_o}, 0);
`else
        // without the M extension, MUL encoding is illegal with 1-cycle latency
        drive(1'b1, I_MUL, 32'h500);
        step();
        check("mul_ill_valid", ctrl_valid_o, 1);
        check("mul_ill_ctrl", ctrl_pack, ctl(0,0,0,0,0,0,0,5'd0,2'd0,2'd0,1));
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("mul_ill_drop", ctrl_valid_o, 0);
`endif

        // flush a held valid bundle while a new instruction is offered
        ctrl_ready_i = 1'b0;
        drive(1'b1, I_ADDI, 32'h800);
        step();
        check("flush_hold_valid", ctrl_valid_o, 1);
        drive(1'b1, I_LBU, 32'h804);
        ctrl_ready_i = 1'b1;
        flush_i      = 1'b1;
        #1;
        check("flush_hold_ready", instr_ready_o, 0);
        step();
        check("flush_hold_cleared", ctrl_valid_o, 0);
        check("flush_hold_pc", pc_o, 32'h800);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("flush_hold_after", ctrl_valid_o, 0);

        // stream of 8 R-type ops
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00208033 | (32'(i + 1) << 7), 32'h400 + 32'(4 * i));
            #1;
            check($sformatf("stream%0d_ready", i), instr_ready_o, 1);
            step();
            check($sformatf("stream%0d_valid", i), ctrl_valid_o, 1);
            check($sformatf("stream%0d_side", i), {pc_o, rd_o},
                  {32'h400 + 32'(4 * i), 5'(i + 1)});
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("stream_drop", ctrl_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
